dr_tx_arbiter: RTL and testbench

DR_TX_ARBITER -- requirements
Module: dr_tx_arbiter

---
 rtl/dr_tx_arbiter_pkg.sv | 23 ++
 rtl/dr_tx_arbiter_sync_ff.sv | 32 +++
 rtl/dr_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_dr_tx_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dr_tx_arbiter_pkg.sv
// Shared definitions for the dual-rail transmit arbiter.
// Holds the handshake FSM state encoding, the dual-rail pair constants
// (NULL / true / false) and a helper that maps one data bit onto its pair.
package dr_tx_arbiter_pkg;

  // Four-phase handshake states seen from the sender side.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_NULL = 2'd2,
    S_ERR  = 2'd3
  } tx_state_t;

  // Pair layout is {true rail, false rail}; 2'b11 is never legal.
  localparam logic [1:0] DR_PAIR_NULL  = 2'b00;
  localparam logic [1:0] DR_PAIR_TRUE  = 2'b10;
  localparam logic [1:0] DR_PAIR_FALSE = 2'b01;

  function automatic logic [1:0] dr_encode_bit(input logic b);
    return b ? DR_PAIR_TRUE : DR_PAIR_FALSE;
  endfunction

endpackage

// File: rtl/dr_tx_arbiter_sync_ff.sv
// sync_ff: plain flip-flop chain that brings an asynchronous level into the
// clk domain.
//   clk  - sampling clock
//   rst  - asynchronous active-high reset, clears every stage
//   d    - asynchronous input level
//   q    - synchronized level, DEPTH clocks behind d
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  // Shift d through the chain; the loop form keeps DEPTH == 1 legal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/dr_tx_arbiter.sv
// dr_tx_arbiter: round-robin arbiter between two word requesters that drives
// the winning word as a dual-rail token into an asynchronous pipeline using a
// four-phase (data / NULL) handshake, with a per-phase timeout.
//   clk, rst                    - clock, asynchronous active-high reset
//   req0_valid/data/ready       - requester 0 word handshake (ready is combinational)
//   req1_valid/data/ready       - requester 1 word handshake
//   dr_data                     - registered dual-rail token, pair i = {true, false} at [2i+1:2i]
//   dr_ack                      - asynchronous ack from the first pipeline stage
//   busy                        - a handshake (or error recovery) is in progress
//   owner                       - requester of the current / last token
//   timeout_err, err_clr        - sticky timeout flag and its clear
module dr_tx_arbiter
  import dr_tx_arbiter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_data,
  output logic               req1_ready,
  output logic [2*WIDTH-1:0] dr_data,
  input  logic               dr_ack,
  output logic               busy,
  output logic               owner,
  output logic               timeout_err,
  input  logic               err_clr
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam int WARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES);

  tx_state_t          state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [WARM_W-1:0]  warm_cnt;
  logic               last_grant;
  logic               ack_s;
  logic               grant;
  logic               offer;
  logic               accept;
  logic [WIDTH-1:0]   sel_data;
  logic [2*WIDTH-1:0] code;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (dr_ack),
    .q   (ack_s)
  );

  // The synchronizer resets to 0, which would look like "ack low" while the
  // stage may still be holding ack high from before reset. Hold off offering
  // until the chain has refilled with real samples of dr_ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt <= '0;
    end else if (warm_cnt != WARM_DONE) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  // Round robin: a lone requester wins outright, a contest goes to whoever
  // did not win last time.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign offer = (state == S_IDLE) && !ack_s && (warm_cnt == WARM_DONE) &&
                 !rst && (req0_valid || req1_valid);
  assign req0_ready = offer && !grant;
  assign req1_ready = offer && grant;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign sel_data   = grant ? req1_data : req0_data;

  // Dual-rail encoding of the winning word, one pair per data bit.
  always_comb begin
    code = '0;
    for (int i = 0; i < WIDTH; i++) begin
      code[2*i +: 2] = dr_encode_bit(sel_data[i]);
    end
  end

  // Handshake FSM. dr_data only ever moves between NULL and a full codeword,
  // and the wait counter is restarted on every phase entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      dr_data     <= '0;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            dr_data    <= code;
            owner      <= grant;
            last_grant <= grant;
            wait_cnt   <= '0;
            state      <= S_DATA;
          end
        end
        S_DATA: begin
          if (ack_s) begin
            dr_data  <= '0;
            wait_cnt <= '0;
            state    <= S_NULL;
          end else if (wait_cnt == CNT_LAST) begin
            dr_data     <= '0;
            timeout_err <= 1'b1;
            state       <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_NULL: begin
          if (!ack_s) begin
            state <= S_IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_ERR: begin
          if (err_clr) begin
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
            state       <= S_NULL;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_dr_tx_arbiter.sv
// Self-checking bench for dr_tx_arbiter: reset values, a table of encoding
// vectors, round-robin contest, timeout / error recovery, reset during a
// token, and a randomized run checked against a queue-based model.
module tb_dr_tx_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [15:0] dr_data;
  logic        dr_ack;
  logic        busy, owner, timeout_err, err_clr;

  dr_tx_arbiter #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .dr_data     (dr_data),
    .dr_ack      (dr_ack),
    .busy        (busy),
    .owner       (owner),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        who;
    logic [7:0]  word;
    logic [15:0] code;
  } vec_t;

  int          total, bad;
  logic        auto_ack;
  int          ack_delay, ack_wait;
  logic        m_s1, m_s2, m_last;
  logic        exp_pending, exp_owner;
  logic [15:0] exp_code, prev_dr;
  logic        got_acc, got_who, last_r0, last_r1;
  int          acc_cnt, trans_cnt;

  // Reference encoding: each bit contributes 2 (true) or 1 (false) in its base-4 digit.
  function automatic logic [15:0] dr_of(input logic [7:0] w);
    int unsigned acc;
    acc = 0;
    for (int i = 0; i < 8; i++) acc += (w[i] ? 2 : 1) * (4 ** i);
    return acc[15:0];
  endfunction

  function automatic logic has11(input logic [15:0] d);
    for (int i = 0; i < 8; i++) if (d[2*i] && d[2*i+1]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check registered outputs, run the ack responder, drive the
  // requester inputs, then check the combinational ready against the model.
  task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                               input logic v1, input logic [7:0] d1, input logic clr);
    logic r0, r1, exp_g;
    @(posedge clk);
    #1;
    if (rst) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_last = 1'b1; exp_pending = 1'b0;
    end else begin
      m_s2 = m_s1; m_s1 = dr_ack;
    end
    if (exp_pending) begin
      checkOutput("accept_code", 32'(dr_data), 32'(exp_code));
      checkOutput("accept_owner", 32'(owner), 32'(exp_owner));
      exp_pending = 1'b0;
    end
    checkOutput("no_11_pair", 32'(has11(dr_data)), 32'd0);
    checkOutput("token_change", 32'(prev_dr != 0 && dr_data != 0 && dr_data != prev_dr), 32'd0);
    if (prev_dr == 0 && dr_data != 0) trans_cnt++;
    prev_dr = dr_data;
    if (auto_ack) begin
      if ((dr_data != 0) != dr_ack) begin
        ack_wait++;
        if (ack_wait >= ack_delay) begin
          dr_ack = ~dr_ack;
          ack_wait = 0;
        end
      end else begin
        ack_wait = 0;
      end
    end
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    err_clr = clr;
    #1;
    r0 = req0_ready; r1 = req1_ready;
    last_r0 = r0; last_r1 = r1;
    checkOutput("ready_exclusive", 32'(r0 && r1), 32'd0);
    checkOutput("ready_gating", 32'((r0 || r1) && (busy || m_s2 || rst)), 32'd0);
    got_acc = 1'b0;
    if ((r0 || r1) && (v0 || v1)) begin
      exp_g = (v0 && v1) ? ~m_last : v1;
      checkOutput("rr_grant", 32'(r1), 32'(exp_g));
      if ((v0 && r0) || (v1 && r1)) begin
        got_acc = 1'b1; got_who = r1; m_last = r1;
        exp_pending = 1'b1; exp_code = dr_of(r1 ? d1 : d0); exp_owner = r1;
        acc_cnt++;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    while (busy && k < 100) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      k++;
    end
    checkOutput(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [6];
    logic [1:0] grants [4];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int n, rdy, acc_start, trans_start;
    logic ok;

    vecs[0] = '{1'b0, 8'hA5, 16'h9966};
    vecs[1] = '{1'b1, 8'h00, 16'h5555};
    vecs[2] = '{1'b0, 8'hFF, 16'hAAAA};
    vecs[3] = '{1'b1, 8'h01, 16'h5556};
    vecs[4] = '{1'b0, 8'h80, 16'h9555};
    vecs[5] = '{1'b1, 8'h3C, 16'h5AA5};

    total = 0; bad = 0; acc_cnt = 0; trans_cnt = 0;
    rst = 1'b1; dr_ack = 1'b0; err_clr = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
    auto_ack = 1'b0; ack_delay = 3; ack_wait = 0;
    m_s1 = 1'b0; m_s2 = 1'b0; m_last = 1'b1; exp_pending = 1'b0;
    exp_owner = 1'b0; exp_code = '0; prev_dr = '0;
    got_acc = 1'b0; got_who = 1'b0; last_r0 = 1'b0; last_r1 = 1'b0;

    // Reset state with both requesters asking.
    repeat (3) applyStimulus(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    checkOutput("reset_ready", 32'({req0_ready, req1_ready}), 32'd0);
    checkOutput("reset_dr_data", 32'(dr_data), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_owner", 32'(owner), 32'd0);
    checkOutput("reset_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Table vectors: single requester, ack model answers after 3 cycles.
    auto_ack = 1'b1; ack_delay = 3;
    for (int v = 0; v < 6; v++) begin
      rdy = 0; ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        applyStimulus(!vecs[v].who, vecs[v].word, vecs[v].who, vecs[v].word, 1'b0);
        rdy += int'(last_r0 || last_r1);
        ok = got_acc;
      end
      checkOutput("vec_accept", 32'(ok), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      checkOutput("vec_code", 32'(dr_data), 32'(vecs[v].code));
      checkOutput("vec_owner", 32'(owner), 32'(vecs[v].who));
      for (int k = 0; k < 40 && busy; k++) begin
        applyStimulus(1'b0, 8'($urandom), 1'b0, 8'($urandom), 1'b0);
        rdy += int'(last_r0 || last_r1);
      end
      checkOutput("vec_idle", 32'(busy), 32'd0);
      checkOutput("vec_null", 32'(dr_data), 32'd0);
      checkOutput("vec_ready_pulses", 32'(rdy), 32'd1);
    end

    // Both requesters hold valid: grants must alternate starting with req0.
    for (int i = 0; i < 4; i++) grants[i] = 2'b11;
    n = 0;
    for (int k = 0; k < 200 && n < 4; k++) begin
      applyStimulus(1'b1, 8'h01, 1'b1, 8'h02, 1'b0);
      if (got_acc) begin
        grants[n] = {1'b0, got_who};
        n++;
      end
    end
    checkOutput("rr_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) checkOutput("rr_sequence", 32'(grants[i]), 32'(i % 2));
    wait_idle("rr_idle");

    // Ack stuck low: ERR after 255 waiting cycles, then recovery via err_clr.
    auto_ack = 1'b0; dr_ack = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
      ok = got_acc;
    end
    checkOutput("to_accept", 32'(ok), 32'd1);
    for (int k = 1; k <= 255; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      if (k == 255) begin
        checkOutput("to_last_wait_err", 32'(timeout_err), 32'd0);
        checkOutput("to_last_wait_data", 32'(dr_data), 32'h6699);
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("to_err_flag", 32'(timeout_err), 32'd1);
    checkOutput("to_err_data", 32'(dr_data), 32'd0);
    checkOutput("to_err_busy", 32'(busy), 32'd1);
    rdy = 0;
    repeat (5) begin
      applyStimulus(1'b1, 8'h77, 1'b1, 8'h88, 1'b0);
      rdy += int'(last_r0 || last_r1);
    end
    checkOutput("to_err_no_ready", 32'(rdy), 32'd0);
    checkOutput("to_err_sticky", 32'(timeout_err), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("to_clr_flag", 32'(timeout_err), 32'd0);
    checkOutput("to_clr_null_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("to_clr_idle", 32'(busy), 32'd0);

    // Reset while a token is on the bus and the stage is acking.
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 8'h33, 1'b0);
      ok = got_acc;
    end
    checkOutput("rst_accept", 32'(ok), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    dr_ack = 1'b1;
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_drop_null", 32'(dr_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd0);
    repeat (2) applyStimulus(1'b1, 8'h44, 1'b1, 8'h55, 1'b0);
    rst = 1'b0;
    rdy = 0;
    repeat (8) begin
      applyStimulus(1'b1, 8'h44, 1'b1, 8'h55, 1'b0);
      rdy += int'(last_r0 || last_r1);
    end
    checkOutput("rst_no_ready_ack_high", 32'(rdy), 32'd0);
    dr_ack = 1'b0;
    applyStimulus(1'b1, 8'h44, 1'b1, 8'h55, 1'b0);
    checkOutput("rst_ready_before_sync", 32'(last_r0 || last_r1), 32'd0);
    applyStimulus(1'b1, 8'h44, 1'b1, 8'h55, 1'b0);
    checkOutput("rst_ready_after_sync", 32'(got_acc), 32'd1);
    checkOutput("rst_first_winner", 32'(got_who), 32'd0);
    auto_ack = 1'b1;
    wait_idle("rst_idle");

    // Randomized traffic against the queue model.
    for (int i = 0; i < 12; i++) begin
      q0.push_back(8'($urandom));
      q1.push_back(8'($urandom));
    end
    acc_start = acc_cnt; trans_start = trans_cnt;
    for (int k = 0; k < 3000 && (q0.size() > 0 || q1.size() > 0); k++) begin
      logic v0, v1;
      logic [7:0] d0, d1;
      v0 = (q0.size() > 0) && ($urandom_range(0, 3) != 0);
      v1 = (q1.size() > 0) && ($urandom_range(0, 3) != 0);
      d0 = v0 ? q0[0] : 8'($urandom);
      d1 = v1 ? q1[0] : 8'($urandom);
      applyStimulus(v0, d0, v1, d1, 1'b0);
      if (got_acc) begin
        if (got_who) void'(q1.pop_front());
        else         void'(q0.pop_front());
        ack_delay = $urandom_range(1, 4);
      end
    end
    wait_idle("rand_idle");
    checkOutput("rand_drained", 32'(q0.size() + q1.size()), 32'd0);
    checkOutput("rand_tokens", 32'(trans_cnt - trans_start), 32'(acc_cnt - acc_start));
    checkOutput("rand_no_timeout", 32'(timeout_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
